uart_tx_cfg: RTL and testbench

Runtime-configurable UART transmitter. It is the parametrised successor to the fixed 8N1 transmitter and supports 5..DATA_WIDTH data bits, none/even/odd parity, 1 or 2 stop bits, and a parametrised oversampling ratio. It sits between the TX FIFO read side and the serial pin, and is paced by the shared baud-tick generator (bclk). The frame configuration is latched at frame start, so software can reprogram it mid-frame without corrupting the frame in flight.

---
 rtl/uart_tx_cfg_if.sv | 26 ++
 rtl/uart_tx_cfg.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_cfg_if.sv
// Upstream-facing bundle of the configurable UART transmitter: frame request,
// payload, frame format and the serial line with its status strobes.
interface uart_tx_cfg_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int NBW = $clog2(DATA_WIDTH + 1);

  logic                  tx_start;
  logic [DATA_WIDTH-1:0] din;
  logic [NBW-1:0]        data_bits;
  logic [1:0]            parity_mode;
  logic                  stop_bits;
  logic                  tx;
  logic                  busy;
  logic                  tx_done;

  modport master (
    output tx_start, din, data_bits, parity_mode, stop_bits,
    input  tx, busy, tx_done
  );

  modport slave (
    input  tx_start, din, data_bits, parity_mode, stop_bits,
    output tx, busy, tx_done
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..DATA_WIDTH data bits, optional
// even/odd parity, 1 or 2 stop bits, OS_RATE bclk ticks per serial bit.
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int OS_RATE    = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bclk,
  uart_tx_cfg_if.slave bus
);
  localparam int NBW = $clog2(DATA_WIDTH + 1);
  localparam int TW  = $clog2(OS_RATE);
  localparam int IW  = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [NBW-1:0]        nbits_q, nbits_d;
  logic                  par_en_q, par_en_d;
  logic                  par_q, par_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [NBW-1:0]        nbits_clamp;
  logic                  par_xor;
  logic                  bit_end;
  logic                  idx_last;

  always_comb begin
    nbits_clamp = bus.data_bits;
    if (bus.data_bits < NBW'(5))
      nbits_clamp = NBW'(5);
    else if (bus.data_bits > NBW'(DATA_WIDTH))
      nbits_clamp = NBW'(DATA_WIDTH);
  end

  // Parity covers only the bits that will actually be sent.
  always_comb begin
    par_xor = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (NBW'(i) < nbits_clamp)
        par_xor = par_xor ^ bus.din[i];
    end
  end

  assign bit_end  = bclk && (tick_q == TW'(OS_RATE - 1));
  assign idx_last = (NBW'(idx_q) == (nbits_q - NBW'(1)));

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    din_d      = din_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    done_d     = 1'b0;

    if (state_q != S_IDLE && bclk)
      tick_d = bit_end ? '0 : tick_q + TW'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.tx_start) begin
          din_d      = bus.din;
          nbits_d    = nbits_clamp;
          par_en_d   = (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
          par_d      = (bus.parity_mode == 2'b10) ? ~par_xor : par_xor;
          stop2_d    = bus.stop_bits;
          tick_d     = '0;
          idx_d      = '0;
          stop_idx_d = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end)
          state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end)
          state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            stop_idx_d = 1'b0;
            state_d    = S_IDLE;
            done_d     = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered from the next state so the line tracks state with no lag.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = din_d[idx_d];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      din_q      <= '0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      din_q      <= din_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.tx_done = done_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed and randomized frames checked
// cycle by cycle against a bit-list model of the expected serial frame.
module tb_uart_tx_cfg;
  localparam int DW  = 8;
  localparam int OS  = 16;
  localparam int NBW = $clog2(DW + 1);

  logic clk = 1'b0;
  logic rst;
  logic bclk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int bclk_period = 1;
  int cyc = 0;

  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_cfg #(.DATA_WIDTH(DW), .OS_RATE(OS)) dut (
    .clk  (clk),
    .rst  (rst),
    .bclk (bclk),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected line levels, one entry per serial bit, from the frame rules.
  function automatic void build_frame(input logic [DW-1:0] d, input int db,
                                      input int pm, input int sb);
    int nb;
    int ones;
    nb = (db < 5) ? 5 : ((db > DW) ? DW : db);
    ones = 0;
    exp_q.delete();
    exp_q.push_back(0);
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back(int'(d[i]));
      ones += int'(d[i]);
    end
    if (pm == 1) exp_q.push_back(ones % 2);
    else if (pm == 2) exp_q.push_back(1 - (ones % 2));
    exp_q.push_back(1);
    if (sb != 0) exp_q.push_back(1);
  endfunction

  // One clock: returns whether bclk was high at that edge, then sets next bclk.
  task automatic tick(output bit ticked);
    @(posedge clk);
    #1;
    ticked = bclk;
    bclk = ((cyc % bclk_period) == 0);
    cyc++;
  endtask

  task automatic idle_check(input int n);
    bit tk;
    for (int i = 0; i < n; i++) begin
      tick(tk);
      check("idle_tx", bus.tx, 1'b1);
      check("idle_busy", bus.busy, 1'b0);
      check("idle_done", bus.tx_done, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input int db, input int pm,
                            input int sb, input bit perturb, input bit hold,
                            input int reset_at);
    bit tk;
    int total;
    int ticks;
    int guard;
    int budget;
    build_frame(d, db, pm, sb);
    total  = OS * exp_q.size();
    budget = total * bclk_period + 8;
    bus.din         = d;
    bus.data_bits   = NBW'(db);
    bus.parity_mode = 2'(pm);
    bus.stop_bits   = 1'(sb);
    bus.tx_start    = 1'b1;
    tick(tk);
    if (!hold) bus.tx_start = 1'b0;
    check("accept_tx", bus.tx, 1'b0);
    check("accept_busy", bus.busy, 1'b1);
    check("accept_done", bus.tx_done, 1'b0);
    ticks = 0;
    guard = 0;
    while (ticks < total) begin
      if (reset_at > 0 && ticks == reset_at) begin
        bus.tx_start = 1'b0;
        rst = 1'b1;
        tick(tk);
        rst = 1'b0;
        check("rst_tx", bus.tx, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.tx_done, 1'b0);
        idle_check(OS * 12);
        return;
      end
      if (perturb) begin
        bus.din         = DW'($urandom);
        bus.data_bits   = NBW'($urandom);
        bus.parity_mode = 2'($urandom);
        bus.stop_bits   = 1'($urandom);
        bus.tx_start    = 1'($urandom);
      end
      tick(tk);
      guard++;
      if (tk) ticks++;
      if (ticks == total) begin
        check("done_pulse", bus.tx_done, 1'b1);
        check("done_busy", bus.busy, 1'b0);
        check("done_tx", bus.tx, 1'b1);
      end else begin
        check("line_bit", bus.tx, 1'(exp_q[ticks / OS]));
        check("busy_hold", bus.busy, 1'b1);
        check("no_early_done", bus.tx_done, 1'b0);
      end
      if (guard > budget) begin
        checks++;
        errors++;
        $error("FAIL frame_timeout: observed %0d ticks expected %0d", ticks, total);
        break;
      end
    end
    bus.tx_start = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bclk            = 1'b0;
    bus.tx_start    = 1'b0;
    bus.din         = '0;
    bus.data_bits   = NBW'(8);
    bus.parity_mode = 2'b00;
    bus.stop_bits   = 1'b0;
    begin
      bit tk;
      repeat (3) tick(tk);
    end
    check("reset_tx", bus.tx, 1'b1);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.tx_done, 1'b0);
    rst = 1'b0;
    idle_check(4);

    bclk_period = 1;
    send_frame(8'hA5, 8, 0, 0, 1'b0, 1'b0, 0);
    idle_check(3);
    send_frame(8'hFF, 7, 1, 1, 1'b0, 1'b0, 0);
    idle_check(3);
    send_frame(8'h00, 3, 2, 0, 1'b0, 1'b0, 0);
    idle_check(3);

    send_frame(8'h3C, 8, 1, 0, 1'b1, 1'b0, 0);
    idle_check(OS * 2);
    send_frame(8'h96, 6, 2, 1, 1'b0, 1'b1, 0);
    send_frame(8'h5A, 8, 0, 0, 1'b0, 1'b0, 0);
    idle_check(3);

    bclk_period = 4;
    send_frame(8'hC3, 8, 0, 0, 1'b0, 1'b0, 0);
    idle_check(8);

    bclk_period = 1;
    send_frame(8'hB7, 8, 0, 0, 1'b0, 1'b0, OS * 4 + 5);
    send_frame(8'h4E, 8, 1, 0, 1'b0, 1'b0, 0);
    idle_check(3);

    for (int n = 0; n < 8; n++) begin
      bclk_period = $urandom_range(1, 3);
      send_frame(DW'($urandom), $urandom_range(0, 15), $urandom_range(0, 3),
                 $urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'b0, 0);
      idle_check(3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
